deser_queue_ctrl: RTL
=====================

// Module: deser_queue_ctrl
// PURPOSE
// - Drains bytes from the serial-to-byte deserializer through its data_ready/ack handshake and stores them in a circular FIFO.
// - Presents the bytes to a downstream consumer on a pop request.
// - Single clock domain (clock_100KHZ); sits between the deserializer and the consumer logic.
// PARAMETERS
// - DEPTH   8  FIFO entries; power of two, >= 2; pointers wrap modulo DEPTH
// - DATA_W  8  byte width; must match the deserializer data_out width
// PORTS
// - clock_100KHZ  in   1  system clock; all logic on the rising edge
// - reset_n       in   1  asynchronous, active-low reset
// - deser_data_in   in   DATA_W  byte from deserializer data_out
// - deser_ready_in  in   1  deserializer data_ready; level, held until acked
// - deser_ack_out   out  1  ack to deserializer ack_in; one-cycle pulse per accepted byte
// - deq_in          in   1  consumer pop request, sampled every cycle
// - data_out        out  DATA_W  popped byte; holds its value until the next pop
// - data_valid_out  out  1  one-cycle pulse: data_out updated this cycle
// - len_out         out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
// - full_out        out  1  len_out == DEPTH
// - empty_out       out  1  len_out == 0
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous): state=IDLE; wr_ptr=rd_ptr=0; len_out=0; empty_out=1; full_out=0.
//   Also deser_ack_out=0; data_valid_out=0; data_out=0. Memory contents are don't-care.
// - Ingress FSM, 2 states, all outputs registered:
//   - IDLE: if deser_ready_in && !full_out (registered value):
//     - mem[wr_ptr]<=deser_data_in; wr_ptr<=wr_ptr+1; deser_ack_out<=1; go WAIT_LOW.
//     - Otherwise stay in IDLE with ack=0. When full, the byte is back-pressured and the deserializer stays parked.
//   - WAIT_LOW: deser_ack_out<=0 unconditionally.
//     - Go IDLE on the first cycle deser_ready_in==0; stay while it is 1.
//     - Guarantees exactly one capture per byte, since the deserializer drops ready one cycle after it samples ack.
//   - Data is captured on the same edge that raises ack, because the deserializer clears data_out on ack.
// - Egress, no FSM:
//   - deq_in && !empty_out (registered): data_out<=mem[rd_ptr]; rd_ptr<=rd_ptr+1; data_valid_out<=1 next cycle.
//   - Otherwise data_valid_out<=0 and data_out holds.
//   - Latency from deq_in to data_valid_out: 1 cycle.
//   - deq_in while empty is ignored: no pointer move, no pulse.
// - Occupancy:
//   - write only: len+1; read only: len-1; write and read in the same cycle: len unchanged.
//   - full_out and empty_out are registered from the next len value.
// - Simultaneous events:
//   - Full + deq_in + deser_ready_in in the same cycle: read happens, write does not (uses registered full). The write is accepted on the following cycle.
//   - Empty + write + deq_in in the same cycle: write only (no bypass). The pop is lost; the consumer must re-request.
// - Wrap-around: pointers are $clog2(DEPTH) bits and roll over naturally. Full/empty are derived from len_out, never from pointer compare.
// - Reset mid-handshake (in WAIT_LOW):
//   - Ack drops immediately and the captured bytes are discarded.
//   - If the deserializer still holds ready after reset release, its byte is accepted fresh (IDLE rule).
// - deser_ack_out is never high for two consecutive cycles.
// TESTING
// - Reset, then one handshake (ready=1, data=8'hA5; ready drops 1 cycle after ack):
//   -> ack high exactly 1 cycle, len_out=1, empty_out=0.
// - Then deq_in=1 for 1 cycle -> next cycle data_out=8'hA5, data_valid_out=1 for 1 cycle, len_out=0, empty_out=1.
// - Push 8 bytes 8'h01..8'h08 (DEPTH=8), then a 9th with ready held:
//   -> full_out=1 and no ack for the 9th.
//   - One pop returns 8'h01; the 9th is acked 1 cycle after full_out falls.
// - Hold deser_ready_in high 5 cycles after ack -> exactly one write, len_out+1 only; FSM stays in WAIT_LOW until ready=0.
// - Fill to 6, then 20 cycles of interleaved push/pop with simultaneous write+read cycles:
//   -> len_out stays consistent, output order is FIFO, and pointers wrap past 7->0 without corruption.
// - deq_in on empty: no data_valid_out and data_out holds its old value.
//   - Then assert reset_n=0 while in WAIT_LOW -> ack=0, len_out=0, empty_out=1 asynchronously.

Source files
------------

// File: rtl/deser_queue_ctrl.sv
// -----------------------------------------------------------------------------
// deser_queue_ctrl
//
// Drains bytes from the serial-to-byte deserializer through its
// data_ready/ack handshake into a circular FIFO. Bytes are handed to the
// downstream consumer one per pop request.
//
// Ports
//   clock_100KHZ    in   1        system clock, rising edge
//   reset_n         in   1        asynchronous active-low reset
//   deser_data_in   in   DATA_W   byte from deserializer data_out
//   deser_ready_in  in   1        deserializer data_ready (level, held until acked)
//   deser_ack_out   out  1        one-cycle ack pulse per accepted byte
//   deq_in          in   1        consumer pop request
//   data_out        out  DATA_W   popped byte, held until the next pop
//   data_valid_out  out  1        one-cycle pulse when data_out updates
//   len_out         out  LEN_W    occupancy 0..DEPTH
//   full_out        out  1        len_out == DEPTH
//   empty_out       out  1        len_out == 0
// -----------------------------------------------------------------------------
module deser_queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clock_100KHZ,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          deser_data_in,
  input  logic                       deser_ready_in,
  output logic                       deser_ack_out,
  input  logic                       deq_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic                full_reg, empty_reg;
  logic                ack_reg, ack_next;
  logic [DATA_W-1:0]   data_out_reg;
  logic                valid_reg;
  logic                wr_en, rd_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Ingress FSM, next-state logic. Capture happens on the same edge that
  // raises ack because the deserializer clears its data_out once it sees ack.
  // WAIT_LOW blocks a second capture while ready is still high from the
  // byte just taken.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    ack_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (deser_ready_in && !full_reg) begin
          wr_en      = 1'b1;
          ack_next   = 1'b1;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!deser_ready_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pops use the registered empty flag, so a write landing in an empty FIFO
  // is not bypassed to a same-cycle pop.
  assign rd_en = deq_in && !empty_reg;

  always_comb begin
    len_next = len_reg;
    case ({wr_en, rd_en})
      2'b10:   len_next = len_reg + LEN_W'(1);
      2'b01:   len_next = len_reg - LEN_W'(1);
      default: len_next = len_reg;
    endcase
  end

  always_ff @(posedge clock_100KHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      len_reg      <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      ack_reg      <= 1'b0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      len_reg   <= len_next;
      full_reg  <= (len_next == LEN_W'(DEPTH));
      empty_reg <= (len_next == '0);
      valid_reg <= rd_en;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // Storage array is not reset so it can map onto block RAM.
  always_ff @(posedge clock_100KHZ) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= deser_data_in;
    end
  end

  assign deser_ack_out  = ack_reg;
  assign data_out       = data_out_reg;
  assign data_valid_out = valid_reg;
  assign len_out        = len_reg;
  assign full_out       = full_reg;
  assign empty_out      = empty_reg;

endmodule
